tlb_fill_ctrl: RTL

TLB refill controller for the data-cache 8-entry fully associative TLB, and the write side of the lookup logic that matches a 20-bit VPN against the eight stored page numbers. On a TLB miss it fetches the PTE through the page-table memory port, picks a victim entry, and writes VPN, PFN and flags into the TLB array. It also reports page faults to the requester. It sits between the dcache miss path, the TLB entry registers and the memory arbiter.

---
 rtl/tlb_fill_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/tlb_fill_ctrl.sv
// TLB refill controller: on a miss walks one PTE, picks a victim entry and writes it,
// or reports a page fault when the PTE is not present.
module tlb_fill_ctrl #(
    parameter int unsigned Entries = 8,
    parameter int unsigned VpnW    = 20,
    parameter int unsigned PfnW    = 20
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               miss_req_i,
    input  logic [VpnW-1:0]    miss_vpn_i,
    output logic               miss_ack_o,
    output logic               fault_o,
    input  logic [9:0]         ptbr_base_i,
    output logic               pte_req_o,
    output logic [31:0]        pte_addr_o,
    input  logic               pte_rdy_i,
    input  logic [31:0]        pte_data_i,
    input  logic [Entries-1:0] entry_valid_i,
    input  logic               flush_i,
    output logic               wr_en_o,
    output logic [2:0]         wr_idx_o,
    output logic [VpnW-1:0]    wr_vpn_o,
    output logic [PfnW-1:0]    wr_pfn_o,
    output logic [1:0]         wr_flags_o
);

    typedef enum logic [2:0] {StIdle, StReq, StFill, StFault, StHold} state_e;

    state_e            state_q, state_d;
    logic [VpnW-1:0]   vpn_q, vpn_d;
    logic [31:0]       pte_addr_q, pte_addr_d;
    logic [2:0]        rr_ptr_q, rr_ptr_d;
    logic [2:0]        wr_idx_q, wr_idx_d;
    logic [VpnW-1:0]   wr_vpn_q, wr_vpn_d;
    logic [PfnW-1:0]   wr_pfn_q, wr_pfn_d;
    logic [1:0]        wr_flags_q, wr_flags_d;

    logic [2:0] victim;
    logic       found_invalid;
    logic       all_valid;

    // Lowest-index invalid entry wins; round-robin only once the array is full.
    always_comb begin
        victim        = rr_ptr_q;
        found_invalid = 1'b0;
        for (int i = 0; i < Entries; i++) begin
            if (!found_invalid && !entry_valid_i[i]) begin
                victim        = 3'(i);
                found_invalid = 1'b1;
            end
        end
        all_valid = &entry_valid_i;
    end

    always_comb begin
        state_d    = state_q;
        vpn_d      = vpn_q;
        pte_addr_d = pte_addr_q;
        rr_ptr_d   = rr_ptr_q;
        wr_idx_d   = wr_idx_q;
        wr_vpn_d   = wr_vpn_q;
        wr_pfn_d   = wr_pfn_q;
        wr_flags_d = wr_flags_q;
        unique case (state_q)
            StIdle: begin
                if (miss_req_i) begin
                    vpn_d      = miss_vpn_i;
                    pte_addr_d = {ptbr_base_i, miss_vpn_i, 2'b00};
                    state_d    = StReq;
                end
            end
            StReq: begin
                if (pte_rdy_i) begin
                    if (pte_data_i[0]) begin
                        wr_vpn_d   = vpn_q;
                        wr_pfn_d   = pte_data_i[31:12];
                        wr_flags_d = {pte_data_i[1], 1'b1};
                        state_d    = StFill;
                    end else begin
                        state_d = StFault;
                    end
                end
            end
            StFill: begin
                wr_idx_d = victim;
                if (all_valid) rr_ptr_d = rr_ptr_q + 3'd1;
                state_d = StHold;
            end
            StFault: state_d = StHold;
            StHold:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (flush_i) rr_ptr_d = 3'd0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            vpn_q      <= '0;
            pte_addr_q <= '0;
            rr_ptr_q   <= '0;
            wr_idx_q   <= '0;
            wr_vpn_q   <= '0;
            wr_pfn_q   <= '0;
            wr_flags_q <= '0;
        end else begin
            state_q    <= state_d;
            vpn_q      <= vpn_d;
            pte_addr_q <= pte_addr_d;
            rr_ptr_q   <= rr_ptr_d;
            wr_idx_q   <= wr_idx_d;
            wr_vpn_q   <= wr_vpn_d;
            wr_pfn_q   <= wr_pfn_d;
            wr_flags_q <= wr_flags_d;
        end
    end

    // A flush landing on the fill cycle drops the write but still acks, forcing a re-lookup.
    assign pte_req_o  = (state_q == StReq);
    assign pte_addr_o = pte_addr_q;
    assign miss_ack_o = (state_q == StFill) || (state_q == StFault);
    assign fault_o    = (state_q == StFault);
    assign wr_en_o    = (state_q == StFill) && !flush_i;
    assign wr_idx_o   = (state_q == StFill) ? victim : wr_idx_q;
    assign wr_vpn_o   = wr_vpn_q;
    assign wr_pfn_o   = wr_pfn_q;
    assign wr_flags_o = wr_flags_q;

endmodule
